// File: rtl/ysyx_22041207_seq_mul.sv
// rtl/ysyx_22041207_seq_mul.sv - iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW
module ysyx_22041207_seq_mul #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   acc_hi;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic              word;

    logic              a_sgn, b_sgn;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic              accept;

    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   acc_hi_nxt, mplier_nxt;
    logic              last;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   res_hi_nxt, res_lo_nxt;

    // 2'b01 decodes as fully unsigned: only the high bit marks A as signed.
    always_comb begin
        a_sgn = mul_signed[1];
        b_sgn = &mul_signed;
        a_ext = multiplicand;
        b_ext = multiplier;
        if (mulw) begin
            a_ext = a_sgn ? {{(XLEN-32){multiplicand[31]}}, multiplicand[31:0]}
                          : {{(XLEN-32){1'b0}}, multiplicand[31:0]};
            b_ext = b_sgn ? {{(XLEN-32){multiplier[31]}}, multiplier[31:0]}
                          : {{(XLEN-32){1'b0}}, multiplier[31:0]};
        end
        a_neg = a_sgn & a_ext[XLEN-1];
        b_neg = b_sgn & b_ext[XLEN-1];
        // The most-negative value negates to itself, which read unsigned is exactly 2^(XLEN-1).
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
    end

    assign accept = (state == S_IDLE) && mul_valid && !flush;

    always_comb begin
        sum        = mplier[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        acc_hi_nxt = sum[XLEN:1];
        mplier_nxt = {sum[0], mplier[XLEN-1:1]};
        last       = (cnt == (word ? CNT_W'(31) : CNT_W'(XLEN-1)));
        // After 32 steps the word product sits straddling acc_hi and the top of mplier.
        prod       = word ? {{(2*XLEN-64){1'b0}}, acc_hi_nxt[31:0], mplier_nxt[XLEN-1 -: 32]}
                          : {acc_hi_nxt, mplier_nxt};
        prod_s     = neg ? -prod : prod;
        res_lo_nxt = word ? {{(XLEN-32){prod_s[31]}}, prod_s[31:0]} : prod_s[XLEN-1:0];
        res_hi_nxt = word ? {XLEN{prod_s[31]}} : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_BUSY;
            S_BUSY: begin
                if (flush)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mul_ready = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc_hi    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            word      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            cnt    <= '0;
            neg    <= a_neg ^ b_neg;
            word   <= mulw;
        end else if (state == S_BUSY && !flush) begin
            acc_hi <= acc_hi_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                result_hi <= res_hi_nxt;
                result_lo <= res_lo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_seq_mul.sv
// tb/tb_ysyx_22041207_seq_mul.sv - scoreboard bench for the sequential multiplier
module tb_ysyx_22041207_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mul_valid = 1'b0;
    logic        flush = 1'b0;
    logic        mulw = 1'b0;
    logic [1:0]  mul_signed = 2'b00;
    logic [63:0] multiplicand = '0;
    logic [63:0] multiplier = '0;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    ysyx_22041207_seq_mul #(.XLEN(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .mul_valid(mul_valid), .flush(flush), .mulw(mulw),
        .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_ready(mul_ready), .out_valid(out_valid),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] last_hi = '0;
    logic [63:0] last_lo = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Reference: full-width two's-complement product, RV64M semantics.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sig, input logic w);
        logic [127:0] xa, xb, p;
        if (w) begin
            p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
            return {{64{p[31]}}, {32{p[31]}}, p[31:0]};
        end
        xa = sig[1]          ? {{64{a[63]}}, a} : {64'b0, a};
        xb = (sig == 2'b11)  ? {{64{b[63]}}, b} : {64'b0, b};
        p  = xa * xb;
        return p;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge with mul_ready=1: the request is taken at the next posedge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sig, input logic w);
        logic [127:0] m;
        exp_t         e;
        multiplicand = a;
        multiplier   = b;
        mul_signed   = sig;
        mulw         = w;
        mul_valid    = 1'b1;
        m    = model(a, b, sig, w);
        e.hi = m[127:64];
        e.lo = m[63:0];
        e.at = cyc + (w ? 33 : 65);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!mul_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mul_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_ready: mul_ready stuck at %b, want 1", mul_ready);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] sig, input logic w);
        int lows = 0;
        wait_ready();
        issue(a, b, sig, w);
        @(negedge clk);
        mul_valid = 1'b0;
        while (!mul_ready && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        check_int("busy_cycles", lows, w ? 33 : 65);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stray_out_valid: got out_valid=1 at cycle %0d, want 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check64("result_hi", result_hi, e.hi);
                    check64("result_lo", result_lo, e.lo);
                    check_int("done_cycle", cyc, e.at);
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        int acc[$];
        int c0;

        #1;
        check_int("reset_ready", int'(mul_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check64("reset_hi", result_hi, 64'h0);
        check64("reset_lo", result_lo, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(64'd3, 64'd5, 2'b00, 1'b0);
        check64("mul_3x5", result_lo, 64'd15);
        run_op(-64'sd3, 64'd7, 2'b11, 1'b0);
        check64("mul_neg_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0);
        check64("mulhu_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10, 1'b0);
        check64("mulhsu_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(64'h7FFF_FFFF, 64'd2, 2'b11, 1'b1);
        check64("mulw_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0);
        check64("minneg_lo", result_lo, 64'h8000_0000_0000_0000);
        check64("minneg_hi", result_hi, 64'h0);
        run_op(64'h1234_5678_8000_0001, 64'hDEAD_BEEF_FFFF_FFFF, 2'b01, 1'b1);

        // Flush ten cycles into an operation, then restart immediately.
        wait_ready();
        issue(64'd11, 64'd13, 2'b00, 1'b0);
        c0 = cyc;
        @(negedge clk);
        mul_valid = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        check_int("ready_after_flush", int'(mul_ready), 1);
        issue(64'd6, 64'd7, 2'b00, 1'b0);
        @(negedge clk);
        mul_valid = 1'b0;
        wait_ready();
        check64("after_flush_lo", result_lo, 64'd42);

        // Flush on the last busy cycle: no write, no strobe.
        wait_ready();
        issue(64'd1000, 64'd1000, 2'b00, 1'b0);
        c0 = cyc;
        @(negedge clk);
        mul_valid = 1'b0;
        while (cyc < c0 + 64) @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        check_int("ready_after_late_flush", int'(mul_ready), 1);
        check64("late_flush_hold_hi", result_hi, last_hi);
        check64("late_flush_hold_lo", result_lo, last_lo);

        // Request coinciding with flush in IDLE is ignored.
        mul_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0;
        flush     = 1'b0;
        check_int("idle_flush_ignored", int'(mul_ready), 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset twenty cycles into an operation.
        wait_ready();
        issue(64'hFFFF_0000_1111_2222, 64'h3333_4444_5555_6666, 2'b00, 1'b0);
        c0 = cyc;
        @(negedge clk);
        mul_valid = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        check_int("midreset_out_valid", int'(out_valid), 0);
        check_int("midreset_ready", int'(mul_ready), 1);
        check64("midreset_hi", result_hi, 64'h0);
        check64("midreset_lo", result_lo, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        run_op(64'd9, 64'd9, 2'b11, 1'b0);
        check64("restart_lo", result_lo, 64'd81);

        // mul_valid held high: accepts land exactly 66 cycles apart.
        wait_ready();
        for (int i = 0; i < 300 && acc.size() < 3; i++) begin
            if (i != 0) @(negedge clk);
            if (mul_ready) begin
                issue(rnd64(), rnd64(), 2'b11, 1'b0);
                acc.push_back(cyc);
            end else begin
                multiplicand = rnd64();
                multiplier   = rnd64();
            end
        end
        @(negedge clk);
        mul_valid = 1'b0;
        check_int("held_accept_count", acc.size(), 3);
        if (acc.size() == 3) begin
            check_int("held_accept_2", acc[1] - acc[0], 66);
            check_int("held_accept_3", acc[2] - acc[0], 132);
        end

        for (int i = 0; i < 30; i++) begin
            run_op(rnd64(), rnd64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (80) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_seq_mul.md
Name: ysyx_22041207_seq_mul

Overview:
Iterative radix-2 shift-add multiplier. It is the responder side of the ALU's multiply handshake: the ALU raises a one-cycle request and stalls until the result pulse arrives. It covers all RV64M multiply forms (MUL, MULH, MULHSU, MULHU, MULW) with one adder and a 128-bit accumulator. A flush input drops an in-flight operation on pipeline redirect.

Parameters:
XLEN, 64, operand width; product is 2*XLEN bits.
CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
mul_valid  input  1  request; sampled only while mul_ready=1
flush  input  1  synchronous abort of any in-flight or requested operation
mulw  input  1  1 = 32-bit word multiply (MULW)
mul_signed  input  2  2'b11 = both signed; 2'b10 = multiplicand signed, multiplier unsigned; 2'b00 = unsigned; 2'b01 = treated as 2'b00
multiplicand  input  XLEN  operand A
multiplier  input  XLEN  operand B
mul_ready  output  1  1 in IDLE only
out_valid  output  1  one-cycle result strobe
result_hi  output  XLEN  upper half of the product (MULH* result)
result_lo  output  XLEN  lower half of the product (MUL/MULW result)

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; mul_ready=1; out_valid=0.
  - result_hi, result_lo, accumulator and counter = 0.
  - Reset asserted mid-operation discards the operation; no out_valid is produced.
- States:
  - IDLE: mul_ready=1. If mul_valid=1 and flush=0:
    - latch |A| and |B| per mul_signed; in mulw mode use the low 32 bits sign-extended when signed, zero-extended otherwise;
    - latch neg = signA XOR signB;
    - clear accumulator, counter=0;
    - go to BUSY.
    - If mul_valid=1 and flush=1: ignore and stay in IDLE.
  - BUSY: each cycle, if the multiplier LSB=1, add the multiplicand into the upper half of the accumulator (carry kept); then shift the {accumulator, multiplier} pair right by one.
    - Iteration count N = XLEN (32 when mulw).
    - On the last iteration (counter = N-1), write result registers at the same edge and go to DONE.
    - The write applies two's-complement negation of the 2*XLEN product when neg=1.
    - mulw: result_lo = sign-extend(product[31:0]); result_hi = replicated bit 31 of the product.
  - DONE: out_valid=1 for exactly this cycle; next state IDLE. mul_valid is ignored here (mul_ready=0).
- Latency: request accepted in cycle T; out_valid is high in cycle T+N+1 (T+65 for 64-bit, T+33 for mulw). Next request can be accepted in T+N+2.
- Results hold their value after out_valid until the next completion or reset; they are not cleared on new accept.
- Flush:
  - flush=1 in BUSY or DONE: return to IDLE next edge.
  - If flush occurs in DONE, out_valid is still high in that cycle; the consumer must ignore it.
  - If flush occurs on the last BUSY cycle, the result write is suppressed and no out_valid follows.
- Boundary cases:
  - Magnitude of the most-negative operand (0x8000_0000_0000_0000) must be handled as an unsigned 2^63 with no overflow.
  - The multiplicand adder is XLEN+1 bits wide.
  - Operand inputs need not be held after the accept cycle.
- mul_signed is decoded only at accept.

Test Plan:
- Unsigned: A=3, B=5, mul_signed=00, valid at T → out_valid at T+65 only, result_lo=15, result_hi=0, mul_ready=0 during T+1..T+65.
- Signed: A=-3, B=7, mul_signed=11 → result_lo=0xFFFF_FFFF_FFFF_FFEB, result_hi=0xFFFF_FFFF_FFFF_FFFF.
- MULHU and MULHSU:
  - A=B=0xFFFF_FFFF_FFFF_FFFF, mul_signed=00 → result_hi=0xFFFF_FFFF_FFFF_FFFE, result_lo=1.
  - A=-1, B=2, mul_signed=10 → result_hi=all ones, result_lo=0xFFFF_FFFF_FFFF_FFFE.
- Word: mulw=1, A=0x7FFF_FFFF, B=2 → out_valid at T+33, result_lo=0xFFFF_FFFF_FFFF_FFFE. Also A=0x8000_0000_0000_0000, B=-1, mul_signed=11, mulw=0 → result_lo=0x8000_0000_0000_0000, result_hi=0.
- Flush: valid at T, flush at T+10 → no out_valid ever, mul_ready=1 at T+11. A new request at T+11 (A=6, B=7) completes at T+76 with result_lo=42.
- Reset and back-to-back:
  - rst low at T+20 → out_valid=0 and results cleared immediately; restart works.
  - mul_valid held high continuously → accepts at T, T+66, T+132 only.
